// File: rtl/pcie_turnoff_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcie_turnoff_ctrl : PME_Turn_Off handler - blocks requests, drains
// outstanding completions and DMA channels, then sends a one-cycle ack.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pcie_turnoff_ctrl #(
  parameter int PEND_W     = 6,
  parameter int CH_NUM     = 4,
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 50000,
  parameter int TMO_EN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_compl_i,
  input  logic              compl_done_i,
  input  logic [CH_NUM-1:0] ch_busy_i,
  input  logic              cfg_to_turnoff_n_i,
  output logic              cfg_turnoff_ok_n_o,
  output logic              req_block_o,
  output logic [PEND_W-1:0] pend_cnt_o,
  output logic              pend_full_o,
  output logic [2:0]        err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01,
    ACK   = 2'b10,
    OFF   = 2'b11
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [2:0]        err_q, err_d;
  logic              ok_n_q, ok_n_d;
  logic              block_q, block_d;
  logic [TMO_W-1:0]  timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    err_d   = err_q;
    timer_d = timer_q;

    // Saturating counter; simultaneous req and done cancel out.
    if (req_compl_i && !compl_done_i) begin
      if (pend_q == PEND_MAX) err_d[1] = 1'b1;
      else                    pend_d   = pend_q + 1'b1;
    end else if (compl_done_i && !req_compl_i) begin
      if (pend_q == '0) err_d[0] = 1'b1;
      else              pend_d   = pend_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!cfg_to_turnoff_n_i) state_d = DRAIN;
      end
      DRAIN: begin
        timer_d = timer_q + 1'b1;
        // Withdrawal beats both drain completion and timeout.
        if (cfg_to_turnoff_n_i) begin
          state_d = IDLE;
        end else if (pend_q == '0 && ch_busy_i == '0 && !req_compl_i) begin
          state_d = ACK;
        end else if (TMO_EN != 0 && timer_q == TMO_LAST) begin
          state_d  = ACK;
          err_d[2] = 1'b1;
        end
      end
      ACK:     state_d = OFF;
      OFF:     if (cfg_to_turnoff_n_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pend_full_d = (pend_d == PEND_MAX);
    ok_n_d      = (state_d != ACK);
    block_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      err_q       <= '0;
      ok_n_q      <= 1'b1;
      block_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      err_q       <= err_d;
      ok_n_q      <= ok_n_d;
      block_q     <= block_d;
      timer_q     <= timer_d;
    end
  end

  assign cfg_turnoff_ok_n_o = ok_n_q;
  assign req_block_o        = block_q;
  assign pend_cnt_o         = pend_q;
  assign pend_full_o        = pend_full_q;
  assign err_o              = err_q;
  assign state_o            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_turnoff_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pcie_turnoff_ctrl : directed and random checks against a cycle-count model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pcie_turnoff_ctrl;

  localparam int PEND_W = 2;
  localparam int CH_NUM = 4;
  localparam int TMO_W  = 8;
  localparam int TMO    = 24;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              done = 1'b0;
  logic [CH_NUM-1:0] busy = '0;
  logic              to_n = 1'b1;
  logic              ok_n, block, full;
  logic [PEND_W-1:0] pend;
  logic [2:0]        err;
  logic [1:0]        state;

  int checks = 0;
  int failures = 0;

  pcie_turnoff_ctrl #(
    .PEND_W(PEND_W), .CH_NUM(CH_NUM), .TMO_W(TMO_W), .TMO_CYCLES(TMO), .TMO_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_compl_i(req), .compl_done_i(done),
    .ch_busy_i(busy), .cfg_to_turnoff_n_i(to_n),
    .cfg_turnoff_ok_n_o(ok_n), .req_block_o(block), .pend_cnt_o(pend),
    .pend_full_o(full), .err_o(err), .state_o(state)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 draining, 2 acknowledging, 3 powered off.
  int       m_pend = 0;
  bit [2:0] m_err = '0;
  int       m_phase = 0;
  int       cyc = 0;
  int       m_enter = 0;

  task automatic model_update();
    int  nphase;
    bit  drained;
    cyc++;
    if (!rst_n) begin
      m_pend = 0; m_err = '0; m_phase = 0;
      return;
    end
    nphase  = m_phase;
    drained = (m_pend == 0) && (busy == 0) && !req;
    if (m_phase == 0 && !to_n) begin
      nphase = 1; m_enter = cyc;
    end else if (m_phase == 1) begin
      if (to_n)                      nphase = 0;
      else if (drained)              nphase = 2;
      else if (cyc - m_enter == TMO) begin nphase = 2; m_err[2] = 1'b1; end
    end else if (m_phase == 2) begin
      nphase = 3;
    end else if (m_phase == 3 && to_n) begin
      nphase = 0;
    end
    m_phase = nphase;
    if (req && !done) begin
      if (m_pend == PMAX) m_err[1] = 1'b1; else m_pend++;
    end else if (done && !req) begin
      if (m_pend == 0) m_err[0] = 1'b1; else m_pend--;
    end
  endtask

  function automatic logic [9:0] exp_vec();
    return {m_phase != 2, m_phase != 0, PEND_W'(m_pend), m_pend == PMAX, m_err, 2'(m_phase)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {ok_n, block, pend, full, err, state};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 0; done = 0; busy = '0; to_n = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 10'b1_0_00_0_000_00) begin
      failures++;
      $display("FAIL reset_values: got %b want %b", dut_vec(), 10'b1_0_00_0_000_00);
    end
  endtask

  task automatic test_idle_turnoff();
    do_reset();
    to_n = 1'b0;
    tick();
    checks++;
    if ({ok_n, block, state} !== 4'b1_1_01) begin
      failures++; $display("FAIL idle_enter_drain: got %b want 1101", {ok_n, block, state});
    end
    tick();
    checks++;
    if ({ok_n, block, state} !== 4'b0_1_10) begin
      failures++; $display("FAIL idle_ack: got %b want 0110", {ok_n, block, state});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({ok_n, block, state} !== 4'b1_1_11) begin
        failures++; $display("FAIL idle_off_%0d: got %b want 1111", i, {ok_n, block, state});
      end
    end
    to_n = 1'b1;
    tick();
    checks++;
    if ({block, state} !== 3'b0_00) begin
      failures++; $display("FAIL off_to_idle: got %b want 000", {block, state});
    end
  endtask

  task automatic test_drain_traffic();
    do_reset();
    for (int i = 0; i < 3; i++) begin req = 1; tick(); end
    req = 0;
    checks++;
    if ({pend, full} !== 3'b11_1) begin
      failures++; $display("FAIL drain_preload: got %b want 111", {pend, full});
    end
    to_n = 1'b0; busy = 4'b0010;
    tick();
    for (int i = 1; i <= 18; i++) begin
      done = (i == 5 || i == 10 || i == 15);
      busy = (i >= 13) ? 4'b0000 : 4'b0010;
      tick();
      done = 0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL drain_step_%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (i == 15) begin
        checks++;
        if ({pend, state} !== 4'b00_01) begin
          failures++; $display("FAIL drain_last_done: got %b want 0001", {pend, state});
        end
      end
      if (i == 16) begin
        checks++;
        if ({ok_n, state, err} !== 6'b0_10_000) begin
          failures++; $display("FAIL drain_ack: got %b want 010000", {ok_n, state, err});
        end
      end
    end
    to_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1; tick(); req = 0;
    to_n = 1'b0;
    tick();
    for (int i = 1; i < TMO; i++) begin
      tick();
      checks++;
      if ({ok_n, state} !== 3'b1_01) begin
        failures++; $display("FAIL timeout_early_%0d: got %b want 101", i, {ok_n, state});
      end
    end
    tick();
    checks++;
    if ({ok_n, state, err} !== 6'b0_10_100) begin
      failures++; $display("FAIL timeout_ack: got %b want 010100", {ok_n, state, err});
    end
    tick();
    to_n = 1'b1;
    tick();
  endtask

  task automatic test_counter_limits();
    do_reset();
    for (int i = 0; i < 4; i++) begin req = 1; tick(); end
    req = 0;
    checks++;
    if ({pend, full, err} !== 6'b11_1_010) begin
      failures++; $display("FAIL overflow: got %b want 111010", {pend, full, err});
    end
    req = 1; done = 1; tick(); req = 0; done = 0;
    checks++;
    if ({pend, full} !== 3'b11_1) begin
      failures++; $display("FAIL req_and_done: got %b want 111", {pend, full});
    end
    for (int i = 0; i < 4; i++) begin done = 1; tick(); end
    done = 0;
    checks++;
    if ({pend, full, err} !== 6'b00_0_011) begin
      failures++; $display("FAIL underflow: got %b want 000011", {pend, full, err});
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    req = 1; tick(); tick(); req = 0;
    to_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({ok_n, state} !== 3'b1_01) begin
        failures++; $display("FAIL abort_drain_%0d: got %b want 101", i, {ok_n, state});
      end
    end
    to_n = 1'b1;
    tick();
    checks++;
    if ({ok_n, block, state} !== 4'b1_0_00) begin
      failures++; $display("FAIL abort_idle: got %b want 1000", {ok_n, block, state});
    end
    done = 1; tick(); tick(); done = 0;
    to_n = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (state !== 2'b11) begin
      failures++; $display("FAIL abort_reach_off: got %b want 11", state);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== 10'b1_0_00_0_000_00) begin
      failures++; $display("FAIL reset_in_off: got %b want %b", dut_vec(), 10'b1_0_00_0_000_00);
    end
    rst_n = 1'b1; to_n = 1'b1;
  endtask

  task automatic test_withdraw_race();
    do_reset();
    to_n = 1'b0; busy = 4'b0001;
    tick(); tick();
    busy = '0; to_n = 1'b1;
    tick();
    checks++;
    if ({ok_n, block, state} !== 4'b1_0_00) begin
      failures++; $display("FAIL withdraw_race: got %b want 1000", {ok_n, block, state});
    end
    tick();
    checks++;
    if (ok_n !== 1'b1) begin
      failures++; $display("FAIL withdraw_no_ack: got %b want 1", ok_n);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      req   = ($urandom_range(0, 9) < 3);
      done  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) to_n = ~to_n;
      if ($urandom_range(0, 9) == 0)
        busy = ($urandom_range(0, 1) != 0) ? CH_NUM'($urandom) : '0;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got %b want %b", i, dut_vec(), exp_vec());
        errs++;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle_turnoff();
    test_drain_traffic();
    test_timeout();
    test_counter_limits();
    test_abort_reset();
    test_withdraw_race();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
